multi_timer: RTL and testbench

//  CHANNELS independent down-counting timers sharing one microsecond prescaler; each channel is one-shot or periodic.

---
 rtl/multi_timer_pkg.sv | 9 +
 rtl/timer_channel.sv | 61 ++++++
 rtl/multi_timer.sv | 54 +++++
 tb/tb_multi_timer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared state type, mode encodings and select-width helper for multi_timer
package multi_timer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;
  function automatic int sel_bits(input int channels);
    return channels > 1 ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer (one-shot/periodic) with level irq; count port only with MULTI_TIMER_READBACK_EN
module timer_channel import multi_timer_pkg::*; #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            tick,
  input  logic            wr,
  input  logic [BITS-1:0] value,
  input  logic            periodic,
  input  logic            clr,
  output logic            irq,
  output logic            running
`ifdef MULTI_TIMER_READBACK_EN
  ,
  output logic [BITS-1:0] count
`endif
);
  state_t state, state_n;
  logic [BITS-1:0] cnt, cnt_n, reload, reload_n;
  logic mode, mode_n, irq_n, expire;
  always_comb begin
    expire = state == RUN && cnt == '0;
    state_n = state;
    cnt_n = cnt;
    reload_n = reload;
    mode_n = mode;
    irq_n = irq & ~clr;
    if (wr) begin
      cnt_n = value;
      reload_n = value;
      mode_n = periodic;
      irq_n = 1'b0;
      state_n = (periodic == PERIODIC && value == '0) ? IDLE : RUN;
    end else if (expire) begin
      irq_n = 1'b1;
      state_n = mode == PERIODIC ? RUN : IDLE;
      cnt_n = mode == PERIODIC ? reload : cnt;
    end else if (state == RUN && tick) begin
      cnt_n = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      state <= IDLE;
      cnt <= '0;
      reload <= '0;
      mode <= ONE_SHOT;
      irq <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      reload <= reload_n;
      mode <= mode_n;
      irq <= irq_n;
    end
  assign running = state == RUN;
`ifdef MULTI_TIMER_READBACK_EN
  assign count = cnt;
`endif
endmodule

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS timers on a shared prescaler; MULTI_TIMER_READBACK_EN adds registered rdata of counter[sel]
module multi_timer import multi_timer_pkg::*; #(
  parameter int BITS           = 32,
  parameter int CHANNELS       = 4,
  parameter int SEL_BITS       = sel_bits(CHANNELS),
  parameter int PRESCALE_BITS  = 5,
  parameter int PRESCALE_VALUE = 26
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                nwr,
  input  logic [SEL_BITS-1:0] sel,
  input  logic [BITS-1:0]     value,
  input  logic                periodic,
  input  logic [CHANNELS-1:0] interrupt_clear,
  output logic [CHANNELS-1:0] interrupt,
  output logic                irq_any,
  output logic [CHANNELS-1:0] running
`ifdef MULTI_TIMER_READBACK_EN
  ,
  output logic [BITS-1:0]     rdata
`endif
);
  logic [PRESCALE_BITS-1:0] prescaler;
  logic tick;
`ifdef MULTI_TIMER_READBACK_EN
  logic [BITS-1:0] count [CHANNELS];
`endif
  assign tick = prescaler == PRESCALE_BITS'(PRESCALE_VALUE);
  always_ff @(posedge clk)
    prescaler <= (!nreset || tick) ? '0 : prescaler + 1'b1;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    timer_channel #(.BITS(BITS)) u_ch (
      .clk      (clk),
      .nreset   (nreset),
      .tick     (tick),
      .wr       (!nwr && sel == SEL_BITS'(c)),
      .value    (value),
      .periodic (periodic),
      .clr      (interrupt_clear[c]),
      .irq      (interrupt[c]),
      .running  (running[c])
`ifdef MULTI_TIMER_READBACK_EN
      ,
      .count    (count[c])
`endif
    );
  end
  assign irq_any = |interrupt;
`ifdef MULTI_TIMER_READBACK_EN
  always_ff @(posedge clk)
    rdata <= (!nreset || int'(sel) >= CHANNELS) ? '0 : count[sel];
`endif
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: randomized + directed bench against a deadline-arithmetic reference model
module tb_multi_timer;
  localparam int BITS = 32;
  localparam int CH = 4;
  localparam int PV = 3;
  localparam int P = PV + 1;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic nwr = 1'b1;
  logic periodic = 1'b0;
  logic [1:0] sel = '0;
  logic [BITS-1:0] value = '0;
  logic [CH-1:0] interrupt_clear = '0;
  logic [CH-1:0] interrupt, running;
  logic irq_any;
`ifdef MULTI_TIMER_READBACK_EN
  logic [BITS-1:0] rdata;
`endif
  int total = 0;
  int bad = 0;
  multi_timer #(.BITS(BITS), .CHANNELS(CH), .SEL_BITS(2), .PRESCALE_BITS(5), .PRESCALE_VALUE(PV)) dut (
    .clk(clk), .nreset(nreset), .nwr(nwr), .sel(sel), .value(value), .periodic(periodic),
    .interrupt_clear(interrupt_clear), .interrupt(interrupt), .irq_any(irq_any), .running(running)
`ifdef MULTI_TIMER_READBACK_EN
    , .rdata(rdata)
`endif
  );
  always #5 clk = ~clk;
  longint n = 0;
  bit m_run [CH];
  bit m_irq [CH];
  bit m_per [CH];
  longint m_dl [CH];
  longint m_rel [CH];
  longint m_rd = 0;
  logic [CH-1:0] prev_int = '0;
  logic [CH-1:0] rise = '0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic longint next_tick(input longint e);
    return (e / P + 1) * P;
  endfunction
  function automatic longint m_count(input int c);
    return m_run[c] ? ((m_dl[c] - 1) / P - n / P) : 0;
  endfunction
  task automatic step();
    logic [CH-1:0] ei, er;
    @(posedge clk);
    m_rd = nreset ? m_count(int'(sel)) : 0;
    if (!nreset) begin
      n = 0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_irq[c] = 0; m_per[c] = 0; m_dl[c] = 0; m_rel[c] = 0;
      end
    end else begin
      n++;
      for (int c = 0; c < CH; c++) begin
        if (!nwr && int'(sel) == c) begin
          m_irq[c] = 0;
          m_per[c] = periodic;
          m_rel[c] = longint'(value);
          m_run[c] = !(periodic && value == 0);
          m_dl[c] = value == 0 ? n + 1 : next_tick(n) + P * (longint'(value) - 1) + 1;
        end else if (m_run[c] && n == m_dl[c]) begin
          m_irq[c] = 1;
          if (m_per[c]) m_dl[c] = n + P * m_rel[c];
          else m_run[c] = 0;
        end else if (interrupt_clear[c]) begin
          m_irq[c] = 0;
        end
      end
    end
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      ei[c] = m_irq[c];
      er[c] = m_run[c];
    end
    check("interrupt", 64'(interrupt), 64'(ei));
    check("running", 64'(running), 64'(er));
    check("irq_any", 64'(irq_any), 64'(|ei));
`ifdef MULTI_TIMER_READBACK_EN
    check("rdata", 64'(rdata), 64'(m_rd));
`endif
    rise = interrupt & ~prev_int;
    prev_int = interrupt;
  endtask
  task automatic wr(input int c, input longint v, input bit p);
    sel = 2'(c);
    value = BITS'(v);
    periodic = p;
    nwr = 1'b0;
    step();
    nwr = 1'b1;
  endtask
  longint w, r, last;
  int cnt;
  longint last_r [CH];
  initial begin
    @(negedge clk);
    step();
    step();
    nreset = 1'b1;
    check("rst_irq", 64'(interrupt), 0);
    check("rst_run", 64'(running), 0);
    wr(0, 5, 0);
    w = n;
    r = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rise[0] && r == 0) r = n;
    end
    check("os_latency", r, w - w % 4 + 4 + 16 + 1);
    check("os_stopped", 64'(running[0]), 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rise[0]) cnt++;
    end
    check("os_norepeat", cnt, 0);
    interrupt_clear = 4'b0001;
    step();
    interrupt_clear = '0;
    wr(1, 3, 1);
    cnt = 0;
    last = 0;
    for (int i = 0; i < 120 && cnt < 6; i++) begin
      interrupt_clear = {2'b00, interrupt[1], 1'b0};
      step();
      if (rise[1]) begin
        if (cnt > 0) check("per_gap", n - last, 12);
        last = n;
        cnt++;
      end
    end
    interrupt_clear = '0;
    check("per_count", cnt, 6);
    wr(1, 0, 1);
    check("stop_run1", 64'(running[1]), 0);
    wr(2, 0, 1);
    check("zero_per_run", 64'(running[2]), 0);
    check("zero_per_irq", 64'(interrupt[2]), 0);
    wr(2, 0, 0);
    check("zero_os_wr", 64'(interrupt[2]), 0);
    step();
    check("zero_os_irq", 64'(interrupt[2]), 1);
    wr(3, 2, 0);
    for (int i = 0; i < 50 && n < m_dl[3] - 1; i++) step();
    interrupt_clear = 4'b1000;
    step();
    interrupt_clear = '0;
    check("exp_clr_irq", 64'(interrupt[3]), 1);
    wr(3, 2, 0);
    check("wr_clears", 64'(interrupt[3]), 0);
    for (int i = 0; i < 50 && n < m_dl[3] - 1; i++) step();
    wr(3, 7, 0);
    check("wr_exp_irq", 64'(interrupt[3]), 0);
    check("wr_exp_run", 64'(running[3]), 1);
`ifdef MULTI_TIMER_READBACK_EN
    step();
    check("wr_exp_rdata", 64'(rdata), 7);
`endif
    for (int c = 0; c < CH; c++) last_r[c] = 0;
    for (int c = 0; c < CH; c++) wr(c, 2 * (c + 1), 1);
    for (int i = 0; i < 220; i++) begin
      interrupt_clear = interrupt;
      sel = 2'(i / 20);
      step();
      for (int c = 0; c < CH; c++)
        if (rise[c]) begin
          if (last_r[c] != 0) check("indep_gap", n - last_r[c], P * 2 * (c + 1));
          last_r[c] = n;
        end
    end
    interrupt_clear = '0;
    nreset = 1'b0;
    step();
    step();
    check("mid_rst_irq", 64'(interrupt), 0);
    check("mid_rst_run", 64'(running), 0);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("post_rst_run", 64'(running), 0);
    for (int i = 0; i < 3000; i++) begin
      nreset = $urandom_range(0, 399) != 0;
      nwr = $urandom_range(0, 5) != 0;
      sel = 2'($urandom_range(0, 3));
      value = BITS'($urandom_range(0, 6));
      periodic = 1'($urandom_range(0, 1));
      interrupt_clear = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      step();
    end
    nreset = 1'b1;
    nwr = 1'b1;
    interrupt_clear = '0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
